// File: rtl/ldmx_dma_pkg.sv
// Shared definitions for the LDMX DMA framer: FSM encoding, magic defaults
// and the trailer word layout.
package ldmx_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_TRAILER
  } state_e;

  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
  localparam logic [7:0] TRL_MAGIC_DEF = 8'h5A;

  localparam int TRL_TRUNC_BIT = 48;
  localparam int TRL_WC_LSB    = 32;
  localparam int TRL_CSUM_LSB  = 0;

  function automatic logic [63:0] make_trailer(input logic [7:0]  magic,
                                               input logic        trunc,
                                               input logic [15:0] wc,
                                               input logic [31:0] csum);
    logic [63:0] t;
    t                       = '0;
    t[63:56]                = magic;
    t[TRL_TRUNC_BIT]        = trunc;
    t[TRL_WC_LSB +: 16]     = wc;
    t[TRL_CSUM_LSB +: 32]   = csum;
    return t;
  endfunction

endpackage

// File: rtl/ldmx_axis_out_stage.sv
// Single registered AXI-Stream output slot; the producer may only load it
// when space_o is high, and the beat is held untouched until it transfers.
module ldmx_axis_out_stage (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic        last_i,
  input  logic [63:0] user_i,
  input  logic        tready_i,
  output logic        tvalid_o,
  output logic [63:0] tdata_o,
  output logic        tlast_o,
  output logic [63:0] tuser_o,
  output logic        space_o
);

  logic        valid_q;
  logic [63:0] data_q;
  logic        last_q;
  logic [63:0] user_q;

  assign space_o  = !valid_q || tready_i;
  assign tvalid_o = valid_q;
  assign tdata_o  = data_q;
  assign tlast_o  = last_q;
  assign tuser_o  = user_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
      user_q  <= user_i;
    end else if (tready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ldmx_dma_framer.sv
// Wraps DAQ payload words into header/payload/trailer DMA frames with
// truncation at MAX_WORDS. Optional trailer checksum: LDMX_DMA_FRAMER_CHECKSUM_EN.
module ldmx_dma_framer
  import ldmx_dma_pkg::*;
#(
  parameter int         MAX_WORDS = 1024,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF,
  parameter logic [7:0] TRL_MAGIC = TRL_MAGIC_DEF
) (
  input  logic        dmaClk,
  input  logic        dmaRst,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_done,
  output logic        in_ready,
  output logic        dmaIbMaster_tValid,
  output logic [63:0] dmaIbMaster_tData,
  output logic        dmaIbMaster_tLast,
  output logic [63:0] dmaIbMaster_tUser,
  input  logic        dmaIbSlave_tReady,
  output logic [31:0] event_count,
  output logic [15:0] trunc_count
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  state_e      state_q;
  logic [15:0] word_cnt_q;
  logic [31:0] event_cnt_q;
  logic [15:0] trunc_cnt_q;
  logic        trunc_q;
  logic        trl_loaded_q;
  logic [31:0] csum_q;

  logic        stage_space;
  logic        accept;
  logic        payload_acc;
  logic        trl_xfer;
  logic        ld_d;
  logic [63:0] ld_data_d;
  logic        ld_last_d;
  logic [63:0] ld_user_d;

  assign in_ready = !dmaRst &&
                    (((state_q == ST_PAYLOAD) && stage_space) || (state_q == ST_DRAIN));
  assign accept      = in_valid && in_ready;
  assign payload_acc = accept && (state_q == ST_PAYLOAD);
  assign trl_xfer    = (state_q == ST_TRAILER) && trl_loaded_q &&
                       dmaIbMaster_tValid && dmaIbSlave_tReady;

  assign event_count = event_cnt_q;
  assign trunc_count = trunc_cnt_q;

  always_comb begin
    ld_d      = 1'b0;
    ld_data_d = '0;
    ld_last_d = 1'b0;
    ld_user_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && stage_space) begin
          ld_d      = 1'b1;
          ld_data_d = {HDR_MAGIC, 24'h0, event_cnt_q};
        end
      end
      ST_PAYLOAD: begin
        if (payload_acc) begin
          ld_d      = 1'b1;
          ld_data_d = in_data;
        end
      end
      ST_TRAILER: begin
        if (!trl_loaded_q && stage_space) begin
          ld_d      = 1'b1;
          ld_data_d = make_trailer(TRL_MAGIC, trunc_q, word_cnt_q, csum_q);
          ld_last_d = 1'b1;
          ld_user_d = {63'h0, trunc_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge dmaClk) begin
    if (dmaRst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      event_cnt_q  <= '0;
      trunc_cnt_q  <= '0;
      trunc_q      <= 1'b0;
      trl_loaded_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && stage_space) state_q <= ST_HEADER;
        end
        ST_HEADER: begin
          if (dmaIbMaster_tValid && dmaIbSlave_tReady) state_q <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (payload_acc) begin
            word_cnt_q <= word_cnt_q + 16'd1;
            // in_done wins over the limit: a complete MAX_WORDS event is not truncated
            if (in_done) begin
              state_q <= ST_TRAILER;
              trunc_q <= 1'b0;
            end else if (word_cnt_q + 16'd1 == MAX_W) begin
              state_q <= ST_DRAIN;
              trunc_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && in_done) state_q <= ST_TRAILER;
        end
        ST_TRAILER: begin
          if (!trl_loaded_q && stage_space) begin
            trl_loaded_q <= 1'b1;
          end else if (trl_xfer) begin
            event_cnt_q  <= event_cnt_q + 32'd1;
            if (trunc_q && (trunc_cnt_q != 16'hFFFF)) trunc_cnt_q <= trunc_cnt_q + 16'd1;
            word_cnt_q   <= '0;
            trunc_q      <= 1'b0;
            trl_loaded_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LDMX_DMA_FRAMER_CHECKSUM_EN
  always_ff @(posedge dmaClk) begin
    if (dmaRst || trl_xfer) begin
      csum_q <= '0;
    end else if (payload_acc) begin
      csum_q <= csum_q ^ in_data[63:32] ^ in_data[31:0];
    end
  end
`else
  assign csum_q = 32'h0;
`endif

  ldmx_axis_out_stage u_out_stage (
    .clk_i    (dmaClk),
    .srst_i   (dmaRst),
    .load_i   (ld_d),
    .data_i   (ld_data_d),
    .last_i   (ld_last_d),
    .user_i   (ld_user_d),
    .tready_i (dmaIbSlave_tReady),
    .tvalid_o (dmaIbMaster_tValid),
    .tdata_o  (dmaIbMaster_tData),
    .tlast_o  (dmaIbMaster_tLast),
    .tuser_o  (dmaIbMaster_tUser),
    .space_o  (stage_space)
  );

endmodule

// File: tb/tb_ldmx_dma_framer.sv
// Self-checking bench for ldmx_dma_framer: directed vector table, reset
// sequence and randomized events against a frame-level scoreboard.
module tb_ldmx_dma_framer;

  localparam int MAXW = 4;

  logic        dmaClk = 1'b0;
  logic        dmaRst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_done = 1'b0;
  logic        in_ready;
  logic        tValid;
  logic [63:0] tData;
  logic        tLast;
  logic [63:0] tUser;
  logic        tready = 1'b0;
  logic [31:0] event_count;
  logic [15:0] trunc_count;

  always #5 dmaClk = ~dmaClk;

  ldmx_dma_framer #(.MAX_WORDS(MAXW)) dut (
    .dmaClk             (dmaClk),
    .dmaRst             (dmaRst),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_done            (in_done),
    .in_ready           (in_ready),
    .dmaIbMaster_tValid (tValid),
    .dmaIbMaster_tData  (tData),
    .dmaIbMaster_tLast  (tLast),
    .dmaIbMaster_tUser  (tUser),
    .dmaIbSlave_tReady  (tready),
    .event_count        (event_count),
    .trunc_count        (trunc_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] csum_sel(input logic [31:0] v);
`ifdef LDMX_DMA_FRAMER_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // ---------------- frame-level reference model ----------------
  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [63:0] u;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] cur_words[$];
  logic [31:0] m_ev = '0;
  logic [15:0] m_tr = '0;

  task automatic model_event();
    int          n, nf;
    logic        tr;
    logic [31:0] cs;
    logic [63:0] t;
    n  = cur_words.size();
    nf = (n > MAXW) ? MAXW : n;
    tr = (n > MAXW);
    exp_q.push_back('{d: {8'hA5, 24'h0, m_ev}, l: 1'b0, u: 64'h0});
    cs = '0;
    for (int k = 0; k < nf; k++) begin
      exp_q.push_back('{d: cur_words[k], l: 1'b0, u: 64'h0});
      cs = cs ^ cur_words[k][63:32] ^ cur_words[k][31:0];
    end
    t        = '0;
    t[63:56] = 8'h5A;
    t[48]    = tr;
    t[47:32] = 16'(nf);
    t[31:0]  = csum_sel(cs);
    exp_q.push_back('{d: t, l: 1'b1, u: {63'h0, tr}});
    m_ev = m_ev + 32'd1;
    if (tr && m_tr != 16'hFFFF) m_tr = m_tr + 16'd1;
  endtask

  // ---------------- downstream ready generator ----------------
  int rmode = 0;   // 0: always ready, 1: toggle, 2: random
  initial begin
    forever begin
      @(posedge dmaClk);
      #1;
      case (rmode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  bit          sb_en = 1'b1;
  bit          stall_chk = 1'b1;
  int          beat_cnt = 0;
  int          acc_cnt = 0;
  bit          in_frame = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_d, prev_u;
  logic        prev_l;
  logic [63:0] last_hdr = '0, last_trl = '0, last_trl_user = '0;

  initial begin
    beat_t b;
    forever begin
      @(negedge dmaClk);
      if (dmaRst) begin
        in_frame   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", tValid, 1'b1);
          chk("stall_data", tData, prev_d);
          chk("stall_last", tLast, prev_l);
          chk("stall_user", tUser, prev_u);
        end
        if (stall_chk && tValid && !tready && acc_cnt < MAXW)
          chk("in_ready_stalled", in_ready, 1'b0);
        if (tValid && tready) begin
          beat_cnt++;
          if (!in_frame) begin
            last_hdr = tData;
            in_frame = 1'b1;
          end
          if (tLast) begin
            last_trl      = tData;
            last_trl_user = tUser;
            in_frame      = 1'b0;
          end
          if (sb_en) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got %h expected no beat", tData);
            end else begin
              b = exp_q.pop_front();
              chk("beat_data", tData, b.d);
              chk("beat_last", tLast, b.l);
              chk("beat_user", tUser, b.u);
            end
          end
        end
        prev_stall = tValid && !tready;
        prev_d     = tData;
        prev_l     = tLast;
        prev_u     = tUser;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send_event();
    int n;
    bit acc;
    int cyc;
    n       = cur_words.size();
    acc_cnt = 0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = cur_words[k];
      in_done  = (k == n - 1);
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge dmaClk);
        acc = in_ready;
        @(posedge dmaClk);
        #1;
        cyc++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got no accept expected accept of word %0d", k);
      end
      acc_cnt++;
    end
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      @(negedge dmaClk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge dmaClk);
    @(negedge dmaClk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          len;
    int          rm;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [15:0] wc;
    logic        tr;
    logic [31:0] cs;
  } vec_t;

  vec_t vt[7];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, cyc, g, len;
    vt[0] = '{3, 0, 64'd1, 64'd2, 16'd3, 1'b0, csum_sel(32'h0)};
    vt[1] = '{6, 0, 64'd1, 64'd2, 16'd4, 1'b1, csum_sel(32'h4)};
    vt[2] = '{4, 0, 64'd1, 64'd2, 16'd4, 1'b0, csum_sel(32'h4)};
    vt[3] = '{5, 1, 64'd1, 64'd2, 16'd4, 1'b1, csum_sel(32'h4)};
    vt[4] = '{4, 1, 64'd1, 64'd2, 16'd4, 1'b0, csum_sel(32'h4)};
    vt[5] = '{2, 0, 64'h00000001_00000002, 64'h00000004_00000008, 16'd2, 1'b0, csum_sel(32'hF)};
    vt[6] = '{1, 2, 64'd1, 64'd2, 16'd1, 1'b0, csum_sel(32'h1)};

    // reset state
    dmaRst = 1'b1;
    repeat (2) @(posedge dmaClk);
    @(negedge dmaClk);
    chk("rst_tvalid", tValid, 1'b0);
    chk("rst_tlast", tLast, 1'b0);
    chk("rst_tdata", tData, 64'h0);
    chk("rst_tuser", tUser, 64'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_event_count", event_count, 32'h0);
    chk("rst_trunc_count", trunc_count, 16'h0);
    @(posedge dmaClk);
    #1;
    dmaRst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      rmode = vt[i].rm;
      cur_words.delete();
      for (int k = 0; k < vt[i].len; k++)
        cur_words.push_back(k == 0 ? vt[i].w0 : (k == 1 ? vt[i].w1 : 64'(k + 1)));
      model_event();
      send_event();
      wait_drain();
      rmode = 0;
      if (i == 0) chk("hdr_first", last_hdr, 64'hA500_0000_0000_0000);
      chk("trl_magic", last_trl[63:56], 8'h5A);
      chk("trl_word_count", last_trl[47:32], vt[i].wc);
      chk("trl_trunc_bit", last_trl[48], vt[i].tr);
      chk("trl_checksum", last_trl[31:0], vt[i].cs);
      chk("trl_tuser0", last_trl_user[0], vt[i].tr);
      chk("event_count", event_count, m_ev);
      chk("trunc_count", trunc_count, m_tr);
      $display("vector %0d: len=%0d trailer=%h tuser0=%0d events=%0d truncs=%0d",
               i, vt[i].len, last_trl, last_trl_user[0], event_count, trunc_count);
    end

    // reset pulsed mid-event after the second payload beat
    sb_en     = 1'b0;
    stall_chk = 1'b0;
    rmode     = 0;
    @(posedge dmaClk);
    #1;
    in_valid = 1'b1;
    in_data  = 64'h1234_5678_9ABC_DEF0;
    in_done  = 1'b0;
    base = beat_cnt;
    cyc  = 0;
    while (beat_cnt < base + 3 && cyc < 100) begin
      @(negedge dmaClk);
      #1;
      cyc++;
    end
    chk("mid_event_beats", 64'(beat_cnt - base), 64'd3);
    @(posedge dmaClk);
    #1;
    dmaRst   = 1'b1;
    in_valid = 1'b0;
    @(posedge dmaClk);
    @(negedge dmaClk);
    chk("midrst_tvalid", tValid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_event_count", event_count, 32'h0);
    chk("midrst_trunc_count", trunc_count, 16'h0);
    @(posedge dmaClk);
    #1;
    dmaRst = 1'b0;
    exp_q.delete();
    m_ev      = '0;
    m_tr      = '0;
    sb_en     = 1'b1;
    stall_chk = 1'b1;
    @(negedge dmaClk);
    chk("post_rst_tvalid", tValid, 1'b0);
    cur_words.delete();
    cur_words.push_back(64'hDEAD_BEEF_0000_0001);
    model_event();
    send_event();
    wait_drain();
    chk("hdr_after_reset", last_hdr, 64'hA500_0000_0000_0000);
    chk("event_count_after_reset", event_count, 32'd1);
    $display("reset sequence: header=%h events=%0d", last_hdr, event_count);

    // randomized back-to-back events
    for (int e = 0; e < 40; e++) begin
      rmode = $urandom_range(0, 2);
      len   = $urandom_range(1, 7);
      cur_words.delete();
      for (int k = 0; k < len; k++)
        cur_words.push_back({$urandom, $urandom});
      model_event();
      send_event();
      $display("random event %0d: len=%0d ready_mode=%0d", e, len, rmode);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge dmaClk);
        #1;
      end
    end
    wait_drain();
    rmode = 0;
    chk("final_event_count", event_count, m_ev);
    chk("final_trunc_count", trunc_count, m_tr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
